eth_rx_pkt_drain: RTL

Downstream consumer of the XGE MAC packet receive interface, in the 156.25 MHz domain. It drives `pkt_rx_ren` whenever the MAC reports a frame available and buffer space exists. It captures each 64-bit word, checks frame framing and length, and re-presents the words on a valid/ready stream toward the user logic. A one-cycle status pulse carries the byte length and error flags of every completed frame.

---
 rtl/eth_rx_pkt_drain_pkg.sv | 28 ++
 rtl/eth_rx_pkt_drain_if.sv | 19 +
 rtl/eth_rx_sync_fifo.sv | 63 ++++++
 rtl/eth_rx_pkt_drain.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkt_drain_pkg.sv
// eth_rx_pkg: shared types for the XGE MAC receive drain.
//   rx_state_e  - drain FSM states (IDLE, RD, GAP)
//   rx_entry_t  - one buffered word {data, sop, eop, mod, err}
//   BYTES_PER_WORD, eop_bytes() - byte accounting for the length counter
package eth_rx_pkg;

    localparam int BYTES_PER_WORD = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP
    } rx_state_e;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } rx_entry_t;

    // Valid bytes in an eop word; the MAC encodes a full word as mod==0.
    function automatic logic [3:0] eop_bytes(input logic [2:0] mod);
        return (mod == 3'd0) ? 4'(BYTES_PER_WORD) : {1'b0, mod};
    endfunction

endpackage

// File: rtl/eth_rx_pkt_drain_if.sv
// eth_rx_pkt_drain_if: valid/ready word stream from the drain to user logic.
//   out_valid/out_ready            - handshake, transfer when both high
//   out_data/out_sop/out_eop/
//   out_mod/out_err                - payload of the head word
// Modports: master (drain side), slave (user side).
interface eth_rx_pkt_drain_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_mod;
    logic        out_err;

    modport master (output out_valid, out_data, out_sop, out_eop, out_mod, out_err,
                    input  out_ready);
    modport slave  (input  out_valid, out_data, out_sop, out_eop, out_mod, out_err,
                    output out_ready);
endinterface

// File: rtl/eth_rx_sync_fifo.sv
// eth_rx_sync_fifo: single-clock FIFO with a registered head word.
//   clk, rst_n      - clock, async active-low reset (empties the FIFO)
//   push, wdata     - write (ignored when full)
//   pop             - advance head (ignored when empty)
//   head            - current head word, valid while !empty
//   empty/full/free - occupancy status; free = DEPTH - count
// DEPTH must be a power of two so the pointers wrap naturally.
module eth_rx_sync_fifo #(
    parameter int  DEPTH = 16,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  T            wdata,
    input  logic        pop,
    output T            head,
    output logic        empty,
    output logic        full,
    output logic [AW:0] free
);

    T              mem [DEPTH];
    T              head_q;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign free      = (AW+1)'(DEPTH) - count;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign rd_ptr_nx = rd_ptr + AW'(do_pop);
    assign head      = head_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // The next head is the word being written when the FIFO is about to
            // hold only that word; otherwise it is already in storage.
            if (do_push && (wr_ptr == rd_ptr_nx)) head_q <= wdata;
            else                                  head_q <= mem[rd_ptr_nx];
        end
    end

endmodule

// File: rtl/eth_rx_pkt_drain.sv
// eth_rx_pkt_drain: drains frames from the XGE MAC receive port into a
// word buffer, checks framing and length, and reports per-frame status.
//   clk156m25, reset_156m25_n      - clock, async active-low reset
//   pkt_rx_avail/pkt_rx_ren        - MAC frame available / read enable
//   pkt_rx_val/data/sop/eop/mod/err- MAC word, returned one cycle after ren
//   out_if (master)                - buffered word stream to user logic
//   frm_done/frm_len/frm_err/
//   frm_oversize                   - one-cycle status per completed frame
// Optional: ETH_RX_DRAIN_STATS_EN adds saturating stat_frames, stat_errors,
// stat_dropped counters.
module eth_rx_pkt_drain
    import eth_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic                 clk156m25,
    input  logic                 reset_156m25_n,
    input  logic                 pkt_rx_avail,
    output logic                 pkt_rx_ren,
    input  logic                 pkt_rx_val,
    input  logic [63:0]          pkt_rx_data,
    input  logic                 pkt_rx_sop,
    input  logic                 pkt_rx_eop,
    input  logic [2:0]           pkt_rx_mod,
    input  logic                 pkt_rx_err,
    eth_rx_pkt_drain_if.master   out_if,
    output logic                 frm_done,
    output logic [15:0]          frm_len,
    output logic                 frm_err,
    output logic                 frm_oversize
`ifdef ETH_RX_DRAIN_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [31:0]          stat_errors,
    output logic [31:0]          stat_dropped
`endif
);

    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    rx_state_e   state_q;
    logic [15:0] len_q;
    logic        ferr_q, in_frame_q;

    logic [AW:0] fifo_free;
    logic        fifo_empty, fifo_full, fifo_push, room, rx_last, rx_take;
    logic        restart, resync, ferr_nx, eop_err, eop_ovs;
    logic [15:0] len_base, len_nx;
    logic [16:0] len_sum;
    rx_entry_t   wr_ent, head;

    // Two free entries: one for the word in flight, one for the word requested now.
    assign room       = (fifo_free >= (AW+1)'(2));
    assign rx_last    = pkt_rx_val && pkt_rx_eop;
    assign pkt_rx_ren = (state_q == ST_RD) && room && !rx_last;
    assign rx_take    = pkt_rx_val && (state_q == ST_RD);
    assign fifo_push  = rx_take && !fifo_full;

    // A word opens a new frame on sop or when no frame is open; opening without
    // sop is a framing error, as is sop inside an open frame (resync).
    assign restart  = pkt_rx_sop || !in_frame_q;
    assign resync   = pkt_rx_sop && in_frame_q;
    assign ferr_nx  = restart ? !pkt_rx_sop : ferr_q;
    assign len_base = restart ? 16'd0 : len_q;
    assign len_sum  = {1'b0, len_base} +
                      {13'd0, (pkt_rx_eop ? eop_bytes(pkt_rx_mod) : 4'(BYTES_PER_WORD))};
    assign len_nx   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign eop_err  = pkt_rx_err | ferr_nx | (len_nx < MIN_L);
    assign eop_ovs  = (len_nx > MAX_L);

    always_comb begin
        wr_ent      = '0;
        wr_ent.data = pkt_rx_data;
        wr_ent.sop  = pkt_rx_sop;
        wr_ent.eop  = pkt_rx_eop;
        wr_ent.mod  = pkt_rx_mod;
        wr_ent.err  = pkt_rx_eop ? (eop_err | eop_ovs) : pkt_rx_err;
    end

    eth_rx_sync_fifo #(.DEPTH(FIFO_DEPTH), .T(rx_entry_t)) u_fifo (
        .clk   (clk156m25),
        .rst_n (reset_156m25_n),
        .push  (fifo_push),
        .wdata (wr_ent),
        .pop   (out_if.out_valid && out_if.out_ready),
        .head  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .free  (fifo_free)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head.data;
    assign out_if.out_sop   = head.sop;
    assign out_if.out_eop   = head.eop;
    assign out_if.out_mod   = head.mod;
    assign out_if.out_err   = head.err;

    always_ff @(posedge clk156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            ferr_q       <= 1'b0;
            in_frame_q   <= 1'b0;
            frm_done     <= 1'b0;
            frm_len      <= '0;
            frm_err      <= 1'b0;
            frm_oversize <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            case (state_q)
                ST_IDLE: if (pkt_rx_avail && room) state_q <= ST_RD;
                ST_RD:   if (rx_last)              state_q <= ST_GAP;
                default:                           state_q <= ST_IDLE;
            endcase
            if (rx_take) begin
                len_q      <= len_nx;
                ferr_q     <= ferr_nx;
                in_frame_q <= !pkt_rx_eop;
                // A single-word frame arriving as a resync reports only its own
                // completion; the truncated frame before it goes unreported.
                if (pkt_rx_eop) begin
                    frm_done     <= 1'b1;
                    frm_len      <= len_nx;
                    frm_err      <= eop_err;
                    frm_oversize <= eop_ovs;
                end else if (resync) begin
                    frm_done     <= 1'b1;
                    frm_len      <= len_q;
                    frm_err      <= 1'b1;
                    frm_oversize <= (len_q > MAX_L);
                end
            end
        end
    end

`ifdef ETH_RX_DRAIN_STATS_EN
    always_ff @(posedge clk156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            stat_frames  <= '0;
            stat_errors  <= '0;
            stat_dropped <= '0;
        end else begin
            if (frm_done && (stat_frames != '1))
                stat_frames <= stat_frames + 32'd1;
            if (frm_done && (frm_err || frm_oversize) && (stat_errors != '1))
                stat_errors <= stat_errors + 32'd1;
            if (pkt_rx_val && (state_q != ST_RD) && (stat_dropped != '1))
                stat_dropped <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule
